hilo_muldiv: RTL and testbench

- Execute-stage multiply/divide unit and HI/LO register pair of the MIPS core.
- Consumes the 5-bit ALU control code from the ALU decoder for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Produces 64-bit products and 32-cycle iterative quotients/remainders into HI/LO.
- Holds the pipeline via stall_o while an operation is in flight; hi_o/lo_o feed the MFHI/MFLO datapath.

---
 rtl/hilo_muldiv.sv | 173 +++++++++++++++++
 tb/tb_hilo_muldiv.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: execute-stage multiply/divide unit with the HI/LO register pair.
// Ports: clk/rst (async active-high); valid_i/flush_i/alucontrol_i/a_i/b_i issue the E-stage op;
//        stall_o holds the pipeline while an op is in flight, busy_o = MUL|DIV, hi_o/lo_o = HI/LO.
// Latency: MULT/MULTU stall 2 cycles, DIV/DIVU stall 33 cycles; MTHI/MTLO write in 1 cycle with no stall.
module hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic             flush_i,
  input  logic [4:0]       alucontrol_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  // ALU control codes, mirroring the core's defines.vh values.
  localparam logic [4:0] MULT_CONTROL  = 5'd13;
  localparam logic [4:0] MULTU_CONTROL = 5'd14;
  localparam logic [4:0] DIV_CONTROL   = 5'd15;
  localparam logic [4:0] DIVU_CONTROL  = 5'd16;
  localparam logic [4:0] MTHI_CONTROL  = 5'd17;
  localparam logic [4:0] MTLO_CONTROL  = 5'd18;

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] a_q, a_d;     // raw rs operand (multiplicand, or dividend for the /0 result)
  logic [WIDTH-1:0] b_q, b_d;     // raw multiplier for MUL, |divisor| for DIV
  logic [WIDTH-1:0] rem_q, rem_d; // partial remainder
  logic [WIDTH-1:0] quo_q, quo_d; // dividend bits shift out the top, quotient bits shift in below
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sgn_q, sgn_d;
  logic             qneg_q, qneg_d; // negate quotient at the end
  logic             rneg_q, rneg_d; // negate remainder at the end

  logic             is_mul, is_div, sgn_op, accept, start;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [2*WIDTH-1:0] ma_x, mb_x, prod;
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] rem_nx, quo_nx;

  assign is_mul = (alucontrol_i == MULT_CONTROL) || (alucontrol_i == MULTU_CONTROL);
  assign is_div = (alucontrol_i == DIV_CONTROL)  || (alucontrol_i == DIVU_CONTROL);
  assign sgn_op = (alucontrol_i == MULT_CONTROL) || (alucontrol_i == DIV_CONTROL);

  // rst gates issue so stall_o stays low while reset is held, even with an op presented.
  assign accept = valid_i & ~flush_i & (state_q == IDLE) & ~rst;
  assign start  = accept & (is_mul | is_div);

  assign a_neg = sgn_op & a_i[WIDTH-1];
  assign b_neg = sgn_op & b_i[WIDTH-1];
  assign a_abs = a_neg ? -a_i : a_i;
  assign b_abs = b_neg ? -b_i : b_i;

  // Low 2*WIDTH bits of the product of extended operands equal the exact signed or unsigned product.
  assign ma_x = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
  assign mb_x = {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
  assign prod = ma_x * mb_x;

  // One restoring-divide step.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign ge      = (shifted >= {1'b0, b_q});
  assign rem_nx  = ge ? (shifted[WIDTH-1:0] - b_q) : shifted[WIDTH-1:0];
  assign quo_nx  = {quo_q[WIDTH-2:0], ge};

  // A flush aborts an in-flight op in the same cycle, so stall must drop with it.
  assign stall_o = start | (((state_q == MUL) || (state_q == DIV)) & ~flush_i);
  assign busy_o  = (state_q == MUL) || (state_q == DIV);
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    case (state_q)
      IDLE: begin
        if (accept && alucontrol_i == MTHI_CONTROL) hi_d = a_i;
        if (accept && alucontrol_i == MTLO_CONTROL) lo_d = a_i;
        if (start) begin
          a_d     = a_i;
          b_d     = is_div ? b_abs : b_i;
          rem_d   = '0;
          quo_d   = a_abs;
          cnt_d   = '0;
          sgn_d   = sgn_op;
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
          state_d = is_mul ? MUL : DIV;
        end
      end
      MUL: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          hi_d    = prod[2*WIDTH-1:WIDTH];
          lo_d    = prod[WIDTH-1:0];
          state_d = DONE;
        end
      end
      DIV: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            // Divide by zero: quotient all-ones, remainder is the raw dividend.
            if (b_q == '0) begin
              lo_d = '1;
              hi_d = a_q;
            end else begin
              lo_d = qneg_q ? -quo_nx : quo_nx;
              hi_d = rneg_q ? -rem_nx : rem_nx;
            end
            state_d = DONE;
          end
        end
      end
      DONE: state_d = IDLE; // the same instruction is still presented; do not re-issue it
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: self-checking bench for hilo_muldiv.
// Directed cases plus randomized ops compared against an arithmetic reference model.
// Inputs driven on the falling edge, outputs sampled 1 time unit later.
module tb_hilo_muldiv;

  localparam logic [4:0] MULT  = 5'd13;
  localparam logic [4:0] MULTU = 5'd14;
  localparam logic [4:0] DIV   = 5'd15;
  localparam logic [4:0] DIVU  = 5'd16;
  localparam logic [4:0] MTHI  = 5'd17;
  localparam logic [4:0] MTLO  = 5'd18;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        flush_i;
  logic [4:0]  alucontrol_i;
  logic [31:0] a_i, b_i;
  logic        stall_o, busy_o;
  logic [31:0] hi_o, lo_o;

  int tests = 0;
  int fails = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  hilo_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .flush_i(flush_i),
    .alucontrol_i(alucontrol_i), .a_i(a_i), .b_i(b_i),
    .stall_o(stall_o), .busy_o(busy_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural definition.
  task automatic ref_op(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    hi = model_hi;
    lo = model_lo;
    case (code)
      MULT:  begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      MULTU: begin p = ua * ub; hi = p[63:32]; lo = p[31:0]; end
      DIV, DIVU: begin
        if (b == 32'h0) begin
          lo = 32'hFFFF_FFFF;
          hi = a;
        end else if (code == DIV) begin
          sq = sa / sb; sr = sa % sb;
          p = sq; lo = p[31:0];
          p = sr; hi = p[31:0];
        end else begin
          p = ua / ub; lo = p[31:0];
          p = ua % ub; hi = p[31:0];
        end
      end
      MTHI: hi = a;
      MTLO: lo = a;
      default: ;
    endcase
  endtask

  // Issue an op and hold it (as a stalled pipeline would) until stall drops; check in DONE.
  task automatic run_op(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    int cnt;
    int exp_cnt;
    logic [31:0] eh, el;
    @(negedge clk);
    valid_i = 1'b1; flush_i = 1'b0; alucontrol_i = code; a_i = a; b_i = b;
    cnt = 0;
    #1;
    while (stall_o && cnt < 100) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    ref_op(code, a, b, eh, el);
    model_hi = eh;
    model_lo = el;
    exp_cnt = (code == MULT || code == MULTU) ? 2 : 33;
    check({tag, "_stall_cycles"}, 64'(cnt), 64'(exp_cnt));
    check({tag, "_hi"}, {32'h0, hi_o}, {32'h0, model_hi});
    check({tag, "_lo"}, {32'h0, lo_o}, {32'h0, model_lo});
    check({tag, "_busy_done"}, {63'h0, busy_o}, 64'h0);
  endtask

  task automatic mt(input logic [4:0] code, input logic [31:0] a, input string tag);
    logic [31:0] eh, el;
    @(negedge clk);
    valid_i = 1'b1; flush_i = 1'b0; alucontrol_i = code; a_i = a; b_i = 32'h0;
    #1;
    check({tag, "_stall"}, {63'h0, stall_o}, 64'h0);
    ref_op(code, a, 32'h0, eh, el);
    model_hi = eh;
    model_lo = el;
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    valid_i = 1'b0; alucontrol_i = 5'd0;
    #1;
    check({tag, "_hi"}, {32'h0, hi_o}, {32'h0, model_hi});
    check({tag, "_lo"}, {32'h0, lo_o}, {32'h0, model_lo});
    check({tag, "_stall"}, {63'h0, stall_o}, 64'h0);
  endtask

  initial begin
    // Reset with an op presented: stall must stay low while in reset.
    rst = 1'b1; valid_i = 1'b1; flush_i = 1'b0; alucontrol_i = MULT; a_i = 32'h5; b_i = 32'h7;
    repeat (3) @(negedge clk);
    #1;
    check("reset_hi", {32'h0, hi_o}, 64'h0);
    check("reset_lo", {32'h0, lo_o}, 64'h0);
    check("reset_stall", {63'h0, stall_o}, 64'h0);
    check("reset_busy", {63'h0, busy_o}, 64'h0);
    valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Directed cases; MULT then MULT back-to-back covers hold-through-DONE and re-accept.
    run_op(MULT,  32'hFFFF_FFFE, 32'h0000_0003, "mult");
    check("mult_hi_lit", {32'h0, hi_o}, 64'hFFFF_FFFF);
    check("mult_lo_lit", {32'h0, lo_o}, 64'hFFFF_FFFA);
    run_op(MULTU, 32'hFFFF_FFFE, 32'h0000_0003, "multu");
    check("multu_hi_lit", {32'h0, hi_o}, 64'h0000_0002);
    run_op(DIV,   32'hFFFF_FFF9, 32'h0000_0002, "div_neg7_2");
    check("div_lo_lit", {32'h0, lo_o}, 64'hFFFF_FFFD);
    check("div_hi_lit", {32'h0, hi_o}, 64'hFFFF_FFFF);
    run_op(DIVU,  32'h0000_0007, 32'h0000_0002, "divu_7_2");
    run_op(DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    check("div_ovf_lo_lit", {32'h0, lo_o}, 64'h8000_0000);
    run_op(DIVU,  32'h1234_5678, 32'h0, "divu_by0");
    run_op(DIV,   32'h1234_5678, 32'h0, "div_by0");
    check("div_by0_lo_lit", {32'h0, lo_o}, 64'hFFFF_FFFF);
    check("div_by0_hi_lit", {32'h0, hi_o}, 64'h1234_5678);
    run_op(MULT,  32'h0000_1234, 32'hFFFF_0001, "mult_b2b");
    idle_check("after_b2b");

    // Flush during divide iteration 10.
    mt(MTHI, 32'hAAAA_0000, "pre_mthi");
    mt(MTLO, 32'h0000_BBBB, "pre_mtlo");
    idle_check("preload");
    @(negedge clk);
    valid_i = 1'b1; alucontrol_i = DIV; a_i = 32'd100; b_i = 32'd7;
    repeat (10) @(negedge clk);
    flush_i = 1'b1;
    #1;
    check("flush_stall_same_cycle", {63'h0, stall_o}, 64'h0);
    check("flush_busy_same_cycle", {63'h0, busy_o}, 64'h1);
    @(negedge clk);
    flush_i = 1'b0; valid_i = 1'b0;
    #1;
    check("flush_busy_after", {63'h0, busy_o}, 64'h0);
    check("flush_hi", {32'h0, hi_o}, 64'hAAAA_0000);
    check("flush_lo", {32'h0, lo_o}, 64'h0000_BBBB);

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      int unsigned sel;
      logic [31:0] ra, rb;
      logic [4:0]  code;
      sel = $urandom_range(0, 5);
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      case (sel)
        0: code = MULT;
        1: code = MULTU;
        2: code = DIV;
        3: code = DIVU;
        4: code = MTHI;
        default: code = MTLO;
      endcase
      if (code == MTHI || code == MTLO) begin
        mt(code, ra, $sformatf("rnd%0d_mt", i));
        idle_check($sformatf("rnd%0d_mtchk", i));
      end else begin
        run_op(code, ra, rb, $sformatf("rnd%0d_op%0d", i, code));
      end
    end
    idle_check("rnd_end");

    // Asynchronous reset between edges in the middle of a divide.
    @(negedge clk);
    valid_i = 1'b1; alucontrol_i = DIVU; a_i = 32'hDEAD_BEEF; b_i = 32'd3;
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_stall", {63'h0, stall_o}, 64'h0);
    check("arst_busy", {63'h0, busy_o}, 64'h0);
    check("arst_hi", {32'h0, hi_o}, 64'h0);
    check("arst_lo", {32'h0, lo_o}, 64'h0);
    valid_i = 1'b0;
    model_hi = '0;
    model_lo = '0;
    @(negedge clk);
    rst = 1'b0;

    // Consecutive MTHI/MTLO.
    mt(MTHI, 32'h0000_0001, "mthi1");
    mt(MTLO, 32'h0000_0002, "mtlo2");
    idle_check("mt_consec");
    check("mt_consec_hi_lit", {32'h0, hi_o}, 64'h1);
    check("mt_consec_lo_lit", {32'h0, lo_o}, 64'h2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
